// File: rtl/md_unit.sv
// md_unit: HI/LO multiply/divide unit for the E stage.
// The result is computed combinationally in the start cycle and parked in a
// temporary pair; a down-counter models the architectural latency before the
// pair is committed to HI/LO.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDOp,
  input  logic        MD_start,
  input  logic        Req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] MD_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  hilo_t       arch_q, arch_d;   // architectural HI/LO
  hilo_t       tmp_q, tmp_d;     // result waiting for the latency to expire

  // Arithmetic on the forwarded operands.
  logic [63:0] prod_s, prod_u;
  logic [31:0] b_div, q_s, r_s, q_u, r_u;
  logic        b_zero, div_ovf;

  assign prod_s  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u  = {32'd0, A} * {32'd0, B};
  assign b_zero  = (B == 32'd0);
  // INT_MIN / -1 overflows; dividing by 1 instead yields the required
  // quotient 0x80000000 and remainder 0 with no extra mux on the result.
  assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  // Divisor is forced non-zero so the divider never sees x/0.
  assign b_div   = (b_zero || div_ovf) ? 32'd1 : B;
  assign q_s     = $signed(A) / $signed(b_div);
  assign r_s     = $signed(A) % $signed(b_div);
  assign q_u     = A / b_div;
  assign r_u     = A % b_div;

  assign busy   = (state_q == RUN);
  assign HI     = arch_q.hi;
  assign LO     = arch_q.lo;

  // Read port for mfhi/mflo, zero otherwise.
  always_comb begin
    MD_out = 32'd0;
    if (MDOp == OP_MFHI)      MD_out = arch_q.hi;
    else if (MDOp == OP_MFLO) MD_out = arch_q.lo;
  end

  // Next-state: start/move-to in IDLE, countdown and commit in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    arch_d  = arch_q;
    tmp_d   = tmp_q;
    case (state_q)
      IDLE: begin
        if (!Req) begin
          if (MD_start && (MDOp >= OP_MULT) && (MDOp <= OP_DIVU)) begin
            state_d = RUN;
            cnt_d   = (MDOp <= OP_MULTU) ? 5'(MULT_CYCLES) : 5'(DIV_CYCLES);
            case (MDOp)
              OP_MULT:  tmp_d = prod_s;
              OP_MULTU: tmp_d = prod_u;
              OP_DIV:   tmp_d = '{hi: r_s, lo: q_s};
              default:  tmp_d = '{hi: r_u, lo: q_u};
            endcase
            // Divide by zero: commit the current values, i.e. no change.
            // HI/LO cannot be written while busy, so this is safe.
            if ((MDOp >= OP_DIV) && b_zero) tmp_d = arch_q;
          end else if (MDOp == OP_MTHI) begin
            arch_d.hi = A;
          end else if (MDOp == OP_MTLO) begin
            arch_d.lo = A;
          end
        end
      end
      default: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q <= 5'd1) begin
          arch_d  = tmp_q;
          state_d = IDLE;
        end
      end
    endcase
  end

  // State register; reset aborts any running operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      arch_q  <= '0;
      tmp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      arch_q  <= arch_d;
      tmp_q   <= tmp_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vectors for md_unit, checked every cycle against a
// cycle-indexed behavioural model plus hand-computed literal expectations.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDOp;
  logic        MD_start, Req;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] MD_out, HI, LO;

  int nvec = 0;
  int nmis = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDOp(MDOp), .MD_start(MD_start), .Req(Req),
    .A(A), .B(B), .busy(busy), .MD_out(MD_out), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Model: architectural values, the pending result and the last cycle
  // index during which the unit must report busy.
  logic [31:0] m_hi, m_lo, r_hi, r_lo;
  logic        r_ok;
  int          cur = 0;
  int          done_at = -1;
  bit          known = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, exp, cur);
    end
  endtask

  // Result of a start, from plain integer arithmetic on magnitudes.
  task automatic calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, na, nb, q, r, p;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r_ok = 1'b1;
    case (op)
      4'd1: begin p = sa * sb; r_hi = p[63:32]; r_lo = p[31:0]; end
      4'd2: begin p = longint'(ua * ub); r_hi = p[63:32]; r_lo = p[31:0]; end
      4'd3: begin
        if (b == 0) r_ok = 1'b0;
        else begin
          na = (sa < 0) ? -sa : sa;
          nb = (sb < 0) ? -sb : sb;
          q = na / nb;
          r = na % nb;
          if ((sa < 0) != (sb < 0)) q = -q;
          if (sa < 0) r = -r;
          r_hi = r[31:0];
          r_lo = q[31:0];
        end
      end
      default: begin
        if (b == 0) r_ok = 1'b0;
        else begin
          q = longint'(ua / ub);
          r = longint'(ua % ub);
          r_hi = r[31:0];
          r_lo = q[31:0];
        end
      end
    endcase
  endtask

  // One clock cycle: apply inputs, compare outputs against the model,
  // advance the model over the coming edge.
  task automatic cyc(input logic [3:0] op, input logic st, input logic rq,
                     input logic [31:0] a, input logic [31:0] b, input logic rst);
    logic exp_busy;
    logic [31:0] exp_md;
    MDOp = op; MD_start = st; Req = rq; A = a; B = b; reset = rst;
    #1;
    exp_busy = (cur <= done_at);
    exp_md   = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
    if (known) begin
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("HI", HI, m_hi);
      chk("LO", LO, m_lo);
      chk("MD_out", MD_out, exp_md);
    end
    if (rst) begin
      m_hi = 0; m_lo = 0; done_at = -1; known = 1;
    end else if (exp_busy) begin
      if (cur == done_at && r_ok) begin m_hi = r_hi; m_lo = r_lo; end
    end else if (!rq) begin
      if (st && op >= 4'd1 && op <= 4'd4) begin
        calc(op, a, b);
        done_at = cur + ((op <= 4'd2) ? 5 : 10);
      end else if (op == 4'd7) m_hi = a;
      else if (op == 4'd8) m_lo = a;
    end
    @(posedge clk);
    @(negedge clk);
    cur++;
  endtask

  task automatic idle();
    cyc(4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  // Issue a start and count the busy cycles that follow (bounded).
  task automatic run_op(input string nm, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int n_exp);
    int n;
    cyc(op, 1'b1, 1'b0, a, b, 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      idle();
      n++;
    end
    chk({nm, "_busy_len"}, n, n_exp);
  endtask

  initial begin
    MDOp = 0; MD_start = 0; Req = 0; A = 0; B = 0; reset = 1;
    @(negedge clk);
    cyc(4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    cyc(4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_mdout", MD_out, 32'd0);

    run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFE);
    cyc(4'd6, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("mflo", MD_out, 32'hFFFF_FFFE);

    // back-to-back: start in the first non-busy cycle
    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5);
    run_op("multu2", 4'd2, 32'hFFFF_FFFF, 32'd2, 5);
    chk("multu_hi", HI, 32'h0000_0001);
    chk("multu_lo", LO, 32'hFFFF_FFFE);

    run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    chk("divovf_lo", LO, 32'h8000_0000);
    chk("divovf_hi", HI, 32'd0);

    run_op("divu", 4'd4, 32'd100, 32'd7, 10);
    chk("divu_lo", LO, 32'd14);
    chk("divu_hi", HI, 32'd2);

    cyc(4'd7, 1'b0, 1'b0, 32'h11, 32'd0, 1'b0);
    cyc(4'd8, 1'b0, 1'b0, 32'h22, 32'd0, 1'b0);
    run_op("divu0", 4'd4, 32'd1234, 32'd0, 10);
    chk("divu0_hi", HI, 32'h11);
    chk("divu0_lo", LO, 32'h22);
    run_op("div0", 4'd3, 32'hFFFF_0000, 32'd0, 10);
    chk("div0_hi", HI, 32'h11);

    cyc(4'd7, 1'b0, 1'b0, 32'h1234, 32'd0, 1'b0);
    cyc(4'd6, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("mthi_hi", HI, 32'h1234);
    chk("mthi_mflo", MD_out, 32'h22);
    cyc(4'd5, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("mfhi", MD_out, 32'h1234);

    // cancelled start / cancelled move / non-arith start
    cyc(4'd1, 1'b1, 1'b1, 32'd3, 32'd4, 1'b0);
    chk("req_busy", {31'd0, busy}, 32'd0);
    cyc(4'd8, 1'b0, 1'b1, 32'hDEAD, 32'd0, 1'b0);
    chk("req_lo", LO, 32'h22);
    cyc(4'd5, 1'b1, 1'b0, 32'd3, 32'd4, 1'b0);
    chk("badop_busy", {31'd0, busy}, 32'd0);

    // Req and mthi during RUN change nothing; result still lands
    cyc(4'd1, 1'b1, 1'b0, 32'd6, 32'hFFFF_FFF9, 1'b0);
    cyc(4'd7, 1'b0, 1'b1, 32'h5555, 32'd0, 1'b0);
    cyc(4'd7, 1'b0, 1'b0, 32'h5555, 32'd0, 1'b0);
    cyc(4'd1, 1'b1, 1'b0, 32'd9, 32'd9, 1'b0);
    idle(); idle(); idle();
    chk("runreq_hi", HI, 32'hFFFF_FFFF);
    chk("runreq_lo", LO, 32'hFFFF_FFD6);

    // reset in the 3rd busy cycle of a div
    cyc(4'd4, 1'b1, 1'b0, 32'd50, 32'd5, 1'b0);
    idle(); idle();
    cyc(4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    chk("rstrun_busy", {31'd0, busy}, 32'd0);
    chk("rstrun_hi", HI, 32'd0);
    chk("rstrun_lo", LO, 32'd0);
    repeat (12) idle();
    chk("rstrun_lo_late", LO, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
